// File: rtl/nco_pkg.sv
// Shared NCO constants: table geometry defaults, quadrant type, LFSR dither constants and the
// quarter-wave sine generator used to fill the lookup table.
package nco_pkg;

    localparam int LUT_AW_DEF = 10;
    localparam int OUT_W_DEF  = 16;

    // x^16 + x^14 + x^13 + x^11 + 1, left-shifting Fibonacci form
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;

    // round(A * sin((i + 0.5) * pi / 2^(lut_aw-1))); argument stays below pi/2 so the Taylor
    // series converges to well beyond output precision and the result is always positive.
    function automatic int rom_word(input int i, input int lut_aw, input int out_w);
        real x;
        real term;
        real s;
        real amp;
        x    = (real'(i) + 0.5) * PI / real'(1 << (lut_aw - 1));
        term = x;
        s    = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        amp = real'((1 << (out_w - 1)) - 1);
        return $rtoi(amp * s + 0.5);
    endfunction

endpackage

// File: rtl/nco_qsin_rom.sv
// Quarter-wave sine table with two independent read ports, one cycle registered read latency.
// No flow control: both ports read every cycle.
module nco_qsin_rom
    import nco_pkg::*;
#(
    parameter int LUT_AW = LUT_AW_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LUT_AW-3:0] addr_a_i,
    input  logic [LUT_AW-3:0] addr_b_i,
    output logic [OUT_W-1:0]  dat_a_o,
    output logic [OUT_W-1:0]  dat_b_o
);

    localparam int DEPTH = 1 << (LUT_AW - 2);

    logic [OUT_W-1:0] rom [DEPTH];
    logic [OUT_W-1:0] dat_a_q;
    logic [OUT_W-1:0] dat_b_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom[g] = OUT_W'(rom_word(g, LUT_AW, OUT_W));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dat_a_q <= '0;
            dat_b_q <= '0;
        end else begin
            dat_a_q <= rom[addr_a_i];
            dat_b_q <= rom[addr_b_i];
        end
    end

    assign dat_a_o = dat_a_q;
    assign dat_b_o = dat_b_q;

endmodule

// File: rtl/costas_nco.sv
// Quadrature NCO: latency 3 from accumulator to sin/cos, en->out_valid 4 edges, no backpressure.
// Define NCO_DITHER_EN to add LFSR dither below the lookup bits before phase truncation.
module costas_nco
    import nco_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int ADJ_W   = 16,
    parameter int LUT_AW  = LUT_AW_DEF,
    parameter int OUT_W   = OUT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [PHASE_W-1:0] cfg_freq,
    input  logic [PHASE_W-1:0] phase_off,
    input  logic               phase_clr,
    input  logic               en,
    input  logic [ADJ_W-1:0]   freq_adj,
    output logic [OUT_W-1:0]   sin_out,
    output logic [OUT_W-1:0]   cos_out,
    output logic               out_valid
);

    localparam logic [LUT_AW-1:0] COS_OFF = LUT_AW'(1 << (LUT_AW - 2));

    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] inc_q, inc_d;
    logic [PHASE_W-1:0] adj_ext;
    logic [PHASE_W-1:0] ph_full;
    logic [LUT_AW-1:0]  ph_q, ph_d;
    logic [LUT_AW-1:0]  ph_cos;
    logic [2:0]         vld_q, vld_d;
    logic               out_valid_q;
    quad_e              q_sin, q_cos;
    quad_e              q_sin_q, q_cos_q;
    logic [LUT_AW-3:0]  addr_sin, addr_cos;
    logic [OUT_W-1:0]   rom_sin, rom_cos;
    logic [OUT_W-1:0]   sin_q, sin_d;
    logic [OUT_W-1:0]   cos_q, cos_d;

    assign adj_ext = PHASE_W'($signed(freq_adj));

    // Step uses the increment held before this edge, so a same-cycle cfg_we only affects later steps.
    always_comb begin
        acc_d = acc_q;
        if (phase_clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + inc_q + adj_ext;
        end
        inc_d = cfg_we ? cfg_freq : inc_q;
        vld_d = {vld_q[1:0], en};
    end

`ifdef NCO_DITHER_EN
    logic [15:0]        lfsr_q, lfsr_d;
    logic [PHASE_W-1:0] dith;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        end
        dith = '0;
        for (int i = 0; i < PHASE_W - LUT_AW && i < 16; i++) begin
            dith[i] = lfsr_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign ph_full = acc_q + phase_off + dith;
`else
    assign ph_full = acc_q + phase_off;
`endif

    assign ph_d   = LUT_AW'(ph_full >> (PHASE_W - LUT_AW));
    assign ph_cos = ph_q + COS_OFF;

    // Odd quadrants walk the quarter table backwards.
    always_comb begin
        q_sin    = quad_e'(ph_q[LUT_AW-1 -: 2]);
        q_cos    = quad_e'(ph_cos[LUT_AW-1 -: 2]);
        addr_sin = ph_q[LUT_AW-3:0];
        addr_cos = ph_cos[LUT_AW-3:0];
        if (q_sin inside {Q1, Q3}) begin
            addr_sin = ~ph_q[LUT_AW-3:0];
        end
        if (q_cos inside {Q1, Q3}) begin
            addr_cos = ~ph_cos[LUT_AW-3:0];
        end
    end

    nco_qsin_rom #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_rom (
        .clk      (clk),
        .reset    (reset),
        .addr_a_i (addr_sin),
        .addr_b_i (addr_cos),
        .dat_a_o  (rom_sin),
        .dat_b_o  (rom_cos)
    );

    always_comb begin
        sin_d = (q_sin_q inside {Q2, Q3}) ? -rom_sin : rom_sin;
        cos_d = (q_cos_q inside {Q2, Q3}) ? -rom_cos : rom_cos;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            inc_q       <= '0;
            vld_q       <= '0;
            ph_q        <= '0;
            q_sin_q     <= Q0;
            q_cos_q     <= Q0;
            sin_q       <= '0;
            cos_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            inc_q       <= inc_d;
            vld_q       <= vld_d;
            ph_q        <= ph_d;
            q_sin_q     <= q_sin;
            q_cos_q     <= q_cos;
            sin_q       <= sin_d;
            cos_q       <= cos_d;
            out_valid_q <= vld_q[2];
        end
    end

    assign sin_out   = sin_q;
    assign cos_out   = cos_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_costas_nco.sv
// Bench for costas_nco: directed steps plus randomized traffic against an ideal-sinusoid phase model.
module tb_costas_nco;

    localparam real    PI   = 3.14159265358979323846;
    localparam longint MASK = 64'hFFFFFF;
    localparam longint AMP2 = 64'd1073676289;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        cfg_we    = 1'b0;
    logic [23:0] cfg_freq  = '0;
    logic [23:0] phase_off = '0;
    logic        phase_clr = 1'b0;
    logic        en        = 1'b0;
    logic [15:0] freq_adj  = '0;
    logic [15:0] sin_out;
    logic [15:0] cos_out;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit z;
        bit v;
        int ph;
    } ent_t;

    ent_t   pipe[$];
    ent_t   cur;
    longint m_acc;
    longint m_inc;
    bit     m_prev_en;
    int     sv[1024];
    int     cv[1024];
    int     tbl_s[4] = '{101, 32767, -101, -32767};
    int     tbl_c[4] = '{32767, -101, -32767, 101};

    costas_nco dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_freq  (cfg_freq),
        .phase_off (phase_off),
        .phase_clr (phase_clr),
        .en        (en),
        .freq_adj  (freq_adj),
        .sin_out   (sin_out),
        .cos_out   (cos_out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Ideal sample at the centre of lookup cell ph, rounded half away from zero.
    function automatic int ref_val(input int ph, input bit is_cos);
        real a;
        real x;
        real m;
        int  r;
        a = 2.0 * PI * (real'(ph) + 0.5) / 1024.0;
        x = is_cos ? $cos(a) : $sin(a);
        m = 32767.0 * ((x < 0.0) ? -x : x);
        r = $rtoi(m + 0.5);
        return (x < 0.0) ? -r : r;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output after an edge reflects the phase S1 latched two edges earlier; the two seeded
    // entries stand for the cleared output register and the cleared phase register.
    task automatic model_reset();
        pipe.delete();
        pipe.push_back('{z: 1'b1, v: 1'b0, ph: 0});
        pipe.push_back('{z: 1'b0, v: 1'b0, ph: 0});
        m_acc     = 0;
        m_inc     = 0;
        m_prev_en = 1'b0;
    endtask

    task automatic check_out();
        logic signed [31:0] es;
        logic signed [31:0] ec;
        es = cur.z ? 0 : ref_val(cur.ph, 1'b0);
        ec = cur.z ? 0 : ref_val(cur.ph, 1'b1);
        chk("model_sin", $signed(sin_out), es);
        chk("model_cos", $signed(cos_out), ec);
        chk("model_vld", {31'd0, out_valid}, {31'd0, (cur.v && !cur.z)});
    endtask

    task automatic step();
        ent_t e;
        @(posedge clk);
        if (reset) begin
            model_reset();
            cur = '{z: 1'b1, v: 1'b0, ph: 0};
        end else begin
            e.z = 1'b0;
            e.v = m_prev_en;
            e.ph = int'(((m_acc + longint'(phase_off)) & MASK) >> 14);
            pipe.push_back(e);
            m_prev_en = en;
            if (phase_clr) begin
                m_acc = 0;
            end else if (en) begin
                m_acc = (m_acc + m_inc + longint'($signed(freq_adj))) & MASK;
            end
            if (cfg_we) begin
                m_inc = longint'(cfg_freq);
            end
            cur = pipe.pop_front();
        end
        #1;
        check_out();
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        en        = 1'b0;
        cfg_we    = 1'b0;
        phase_clr = 1'b0;
        freq_adj  = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        longint p;
        longint d;

        model_reset();

        // Reset held with en high, then valid latency after release
        en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("rst_sin", $signed(sin_out), 0);
        chk("rst_cos", $signed(cos_out), 0);
        chk("rst_vld", {31'd0, out_valid}, 0);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("valid_lat", {31'd0, out_valid}, (i >= 4) ? 1 : 0);
        end

        // Quarter-turn steps
        do_reset();
        cfg_we   = 1'b1;
        cfg_freq = 24'h400000;
        step();
        cfg_we = 1'b0;
        en     = 1'b1;
        n      = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (cur.v && !cur.z) begin
                n++;
                chk("q_sin", $signed(sin_out), tbl_s[n % 4]);
                chk("q_cos", $signed(cos_out), tbl_c[n % 4]);
            end
        end

        // Same with a quarter-turn phase offset: sin follows the previous cos
        do_reset();
        phase_off = 24'h400000;
        cfg_we    = 1'b1;
        step();
        cfg_we = 1'b0;
        en     = 1'b1;
        n      = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (cur.v && !cur.z) begin
                n++;
                chk("off_sin", $signed(sin_out), tbl_c[n % 4]);
            end
        end

        // Large negative correction, accumulator wrap over many samples
        do_reset();
        phase_off = '0;
        cfg_we    = 1'b1;
        cfg_freq  = 24'h400000;
        step();
        cfg_we   = 1'b0;
        freq_adj = 16'h8000;
        en       = 1'b1;
        for (int i = 0; i < 1003; i++) step();
        chk("wrap_acc", int'(m_acc), int'((1003 * 64'h3F8000) & MASK));

        // Load and step in the same cycle, then clear overriding en
        do_reset();
        freq_adj = '0;
        cfg_we   = 1'b1;
        cfg_freq = 24'h100000;
        en       = 1'b1;
        step();
        cfg_we = 1'b0;
        step();
        en = 1'b0;
        step();
        step();
        chk("same_cyc_sin0", $signed(sin_out), 101);
        step();
        chk("same_cyc_sin1", $signed(sin_out), ref_val(64, 1'b0));
        en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        phase_clr = 1'b1;
        step();
        phase_clr = 1'b0;
        en        = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("clr_sin", $signed(sin_out), 101);
        chk("clr_cos", $signed(cos_out), 32767);

        // Full phase sweep: power and odd symmetry
        do_reset();
        cfg_we   = 1'b1;
        cfg_freq = 24'h004000;
        step();
        cfg_we = 1'b0;
        en     = 1'b1;
        for (int i = 0; i < 1030; i++) begin
            step();
            if (cur.v && !cur.z) begin
                sv[cur.ph] = int'($signed(sin_out));
                cv[cur.ph] = int'($signed(cos_out));
            end
        end
        for (int k = 0; k < 1024; k++) begin
            p = longint'(sv[k]) * sv[k] + longint'(cv[k]) * cv[k];
            d = (p > AMP2) ? p - AMP2 : AMP2 - p;
            chk("power", (d * 1000 <= AMP2) ? 1 : 0, 1);
        end
        for (int k = 0; k < 512; k++) begin
            chk("odd_sym", sv[k], -sv[k + 512]);
        end

        // Randomized traffic
        reset     = 1'b1;
        phase_off = 24'($urandom);
        step();
        reset = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            en        = ($urandom_range(3) != 0);
            phase_clr = ($urandom_range(31) == 0);
            cfg_we    = ($urandom_range(15) == 0);
            cfg_freq  = 24'($urandom);
            freq_adj  = 16'($urandom);
            step();
        end

        // Asynchronous reset mid-run clears everything including the loaded increment
        reset = 1'b1;
        #1;
        chk("arst_sin", $signed(sin_out), 0);
        chk("arst_cos", $signed(cos_out), 0);
        chk("arst_vld", {31'd0, out_valid}, 0);
        phase_off = '0;
        phase_clr = 1'b0;
        cfg_we    = 1'b0;
        freq_adj  = '0;
        step();
        reset = 1'b0;
        en    = 1'b1;
        for (int i = 0; i < 8; i++) step();
        chk("post_rst_sin", $signed(sin_out), 101);
        chk("post_rst_vld", {31'd0, out_valid}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
